// File: rtl/cacheline_burst_adaptor.sv
// Bridges LLC line requests to a beat-oriented burst memory port: splits write-back lines into
// beats, assembles read beats into a line, and aborts bursts whose memory side stalls too long.
module cacheline_burst_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    output logic               err_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned BEATS  = LINE_W / BURST_W;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [TMR_W-1:0]  TIMER_MAX = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    typedef enum logic [1:0] {
        StIdle,
        StRdBurst,
        StWrBurst,
        StDone
    } state_e;

    state_e                          state_q;
    logic [BEAT_W-1:0]               beat_q;
    logic [TMR_W-1:0]                timer_q;
    logic [ADDR_W-1:0]               addr_q;
    logic [BEATS-1:0][BURST_W-1:0]   wbuf_q;
    logic [BEATS-1:0][BURST_W-1:0]   line_q;
    logic                            err_q;
    logic                            timeout;

    // Fires on the last silent cycle the memory is allowed before the burst is abandoned.
    assign timeout = (TIMEOUT != 0) && !resp_i && (timer_q == TIMER_MAX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            timer_q <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (read_i || write_i) begin
                        addr_q  <= address_i & ADDR_MASK;
                        beat_q  <= '0;
                        timer_q <= '0;
                        // A simultaneous write is dropped; the read takes the port.
                        if (read_i) begin
                            state_q <= StRdBurst;
                        end else begin
                            wbuf_q  <= line_i;
                            state_q <= StWrBurst;
                        end
                    end
                end
                StRdBurst, StWrBurst: begin
                    if (resp_i) begin
                        timer_q <= '0;
                        if (state_q == StRdBurst) begin
                            line_q[beat_q] <= burst_i;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_q <= StDone;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else if (TIMEOUT != 0) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                StDone: begin
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        read_o    = (state_q == StRdBurst);
        write_o   = (state_q == StWrBurst);
        resp_o    = (state_q == StDone);
        err_o     = (state_q == StDone) && err_q;
        address_o = (read_o || write_o) ? addr_q : '0;
        burst_o   = write_o ? wbuf_q[beat_q] : '0;
        line_o    = line_q;
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench: three adaptors (default, short timeout, 512/128 geometry) driven in lockstep.
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  address_i;
    logic         read_i, write_i, resp_i;
    logic [255:0] line_i;
    logic [63:0]  burst_i;
    logic [511:0] line2_i;
    logic [127:0] burst2_i;

    logic [255:0] d_line, t_line;
    logic [511:0] w_line;
    logic [63:0]  d_burst, t_burst;
    logic [127:0] w_burst;
    logic [31:0]  d_addr, t_addr, w_addr;
    logic         d_resp, d_err, d_rd, d_wr;
    logic         t_resp, t_err, t_rd, t_wr;
    logic         w_resp, w_err, w_rd, w_wr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cacheline_burst_adaptor dut_d (
        .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(d_line),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(d_resp),
        .err_o(d_err), .burst_i(burst_i), .burst_o(d_burst), .address_o(d_addr),
        .read_o(d_rd), .write_o(d_wr), .resp_i(resp_i)
    );

    cacheline_burst_adaptor #(.TIMEOUT(8)) dut_t (
        .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(t_line),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(t_resp),
        .err_o(t_err), .burst_i(burst_i), .burst_o(t_burst), .address_o(t_addr),
        .read_o(t_rd), .write_o(t_wr), .resp_i(resp_i)
    );

    cacheline_burst_adaptor #(.LINE_W(512), .BURST_W(128)) dut_w (
        .clk(clk), .reset_n(reset_n), .line_i(line2_i), .line_o(w_line),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(w_resp),
        .err_o(w_err), .burst_i(burst2_i), .burst_o(w_burst), .address_o(w_addr),
        .read_o(w_rd), .write_o(w_wr), .resp_i(resp_i)
    );

    function automatic logic [63:0] pat(input int unsigned s, input int unsigned b);
        return {8'(s), 8'(b), 48'h5A5A_F00D_1234};
    endfunction

    function automatic logic [127:0] pat2(input int unsigned s, input int unsigned b);
        return {pat(s, b), ~pat(s, b)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        n_checks++;
        if ({d_rd, d_wr, d_resp, d_err, t_rd, t_wr, t_resp, t_err, w_rd, w_wr, w_resp, w_err}
            !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b %b %b %b, want all 0", d_rd, d_wr, d_resp, d_err);
        end
        n_checks++;
        if (d_line !== '0 || w_line !== '0 || d_addr !== 32'h0 || w_addr !== 32'h0 ||
            d_burst !== 64'h0 || w_burst !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: line_o=%h address_o=%h burst_o=%h, want 0",
                     d_line, d_addr, d_burst);
        end
        reset_n = 1'b1;
        tick;
        n_checks++;
        if (d_rd !== 1'b0 || d_resp !== 1'b0 || d_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: read_o=%b resp_o=%b address_o=%h, want 0 0 0",
                     d_rd, d_resp, d_addr);
        end
    endtask

    task automatic test_read;
        logic [255:0] exp_line;
        logic [511:0] exp_line2;
        exp_line  = {pat(1, 3), pat(1, 2), pat(1, 1), pat(1, 0)};
        exp_line2 = {pat2(1, 3), pat2(1, 2), pat2(1, 1), pat2(1, 0)};
        address_i = 32'h1234_567F;
        read_i = 1'b1;
        tick;
        read_i = 1'b0;
        address_i = 32'hFFFF_FFFF;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (d_rd !== 1'b1 || d_wr !== 1'b0 || d_resp !== 1'b0 || d_addr !== 32'h1234_5660) begin
                n_fail++;
                $display("FAIL read_busy beat %0d: read_o=%b write_o=%b resp_o=%b address_o=%h, want 1 0 0 12345660",
                         b, d_rd, d_wr, d_resp, d_addr);
            end
            n_checks++;
            if (w_rd !== 1'b1 || w_addr !== 32'h1234_5640) begin
                n_fail++;
                $display("FAIL read_busy_512 beat %0d: read_o=%b address_o=%h, want 1 12345640",
                         b, w_rd, w_addr);
            end
            burst_i = pat(1, b);
            burst2_i = pat2(1, b);
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        n_checks++;
        if (d_resp !== 1'b1 || d_err !== 1'b0 || d_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: resp_o=%b err_o=%b read_o=%b, want 1 0 0", d_resp, d_err, d_rd);
        end
        n_checks++;
        if (d_line !== exp_line) begin
            n_fail++;
            $display("FAIL read_line: line_o=%h, want %h", d_line, exp_line);
        end
        n_checks++;
        if (w_line !== exp_line2 || w_resp !== 1'b1) begin
            n_fail++;
            $display("FAIL read_line_512: line_o=%h resp_o=%b, want %h 1", w_line, w_resp, exp_line2);
        end
        tick;
        n_checks++;
        if (d_resp !== 1'b0 || d_line !== exp_line) begin
            n_fail++;
            $display("FAIL read_hold: resp_o=%b line_o=%h, want 0 %h", d_resp, d_line, exp_line);
        end
    endtask

    task automatic test_write;
        int n_resp;
        n_resp = 0;
        line_i  = {pat(2, 3), pat(2, 2), pat(2, 1), pat(2, 0)};
        line2_i = {pat2(2, 3), pat2(2, 2), pat2(2, 1), pat2(2, 0)};
        address_i = 32'h0000_ABCD;
        write_i = 1'b1;
        tick;
        write_i = 1'b0;
        line_i = '1;
        line2_i = '1;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 3; g++) begin
                if (d_resp === 1'b1) n_resp++;
                n_checks++;
                if (d_wr !== 1'b1 || d_rd !== 1'b0 || d_burst !== pat(2, b) ||
                    t_burst !== pat(2, b) || d_addr !== 32'h0000_ABC0) begin
                    n_fail++;
                    $display("FAIL write_beat %0d: write_o=%b burst_o=%h address_o=%h, want 1 %h 0000abc0",
                             b, d_wr, d_burst, d_addr, pat(2, b));
                end
                n_checks++;
                if (w_wr !== 1'b1 || w_burst !== pat2(2, b) || w_addr !== 32'h0000_ABC0) begin
                    n_fail++;
                    $display("FAIL write_beat_512 %0d: write_o=%b burst_o=%h address_o=%h, want 1 %h 0000abc0",
                             b, w_wr, w_burst, w_addr, pat2(2, b));
                end
                resp_i = (g == 2);
                tick;
            end
        end
        resp_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (d_resp === 1'b1) n_resp++;
            tick;
        end
        n_checks++;
        if (n_resp !== 1 || d_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL write_resp_count: resp_o pulses=%0d write_o=%b, want 1 0", n_resp, d_wr);
        end
    endtask

    task automatic test_read_write_collision;
        logic [255:0] exp_line;
        int n_resp;
        n_resp = 0;
        exp_line = {pat(3, 3), pat(3, 2), pat(3, 1), pat(3, 0)};
        line_i = {4{64'hDEAD_BEEF_DEAD_BEEF}};
        address_i = 32'h0000_0040;
        read_i = 1'b1;
        write_i = 1'b1;
        tick;
        read_i = 1'b0;
        write_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (d_rd !== 1'b1 || d_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL collision_busy beat %0d: read_o=%b write_o=%b, want 1 0", b, d_rd, d_wr);
            end
            burst_i = pat(3, b);
            burst2_i = pat2(3, b);
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (d_resp === 1'b1) n_resp++;
            n_checks++;
            if (d_wr !== 1'b0 || (c > 0 && d_rd !== 1'b0)) begin
                n_fail++;
                $display("FAIL collision_after %0d: write_o=%b read_o=%b, want 0 0", c, d_wr, d_rd);
            end
            tick;
        end
        n_checks++;
        if (n_resp !== 1 || d_line !== exp_line) begin
            n_fail++;
            $display("FAIL collision_result: resp_o pulses=%0d line_o=%h, want 1 %h",
                     n_resp, d_line, exp_line);
        end
    endtask

    task automatic test_timeout;
        logic [255:0] exp_line;
        address_i = 32'h0000_1000;
        read_i = 1'b1;
        tick;
        read_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            burst_i = pat(4, b);
            burst2_i = pat2(4, b);
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (t_rd !== 1'b1 || t_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait %0d: read_o=%b resp_o=%b, want 1 0", i, t_rd, t_resp);
            end
            tick;
        end
        n_checks++;
        if (t_rd !== 1'b0 || t_resp !== 1'b1 || t_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_abort: read_o=%b resp_o=%b err_o=%b, want 0 1 1", t_rd, t_resp, t_err);
        end
        n_checks++;
        if (d_rd !== 1'b1 || d_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_long_still_busy: read_o=%b resp_o=%b, want 1 0", d_rd, d_resp);
        end
        tick;
        n_checks++;
        if (t_resp !== 1'b0 || t_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: resp_o=%b err_o=%b, want 0 0", t_resp, t_err);
        end
        // Finish the long-timeout instances; the short one sits in idle and must ignore resp_i.
        for (int b = 2; b < 4; b++) begin
            burst_i = pat(4, b);
            burst2_i = pat2(4, b);
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        exp_line = {pat(4, 3), pat(4, 2), pat(4, 1), pat(4, 0)};
        n_checks++;
        if (d_resp !== 1'b1 || d_err !== 1'b0 || d_line !== exp_line || t_rd !== 1'b0 ||
            t_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_long_done: resp_o=%b err_o=%b line_o=%h short read_o=%b resp_o=%b, want 1 0 %h 0 0",
                     d_resp, d_err, d_line, t_rd, t_resp, exp_line);
        end
        tick;
        exp_line = {pat(5, 3), pat(5, 2), pat(5, 1), pat(5, 0)};
        read_i = 1'b1;
        tick;
        read_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            burst_i = pat(5, b);
            burst2_i = pat2(5, b);
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        n_checks++;
        if (t_resp !== 1'b1 || t_err !== 1'b0 || t_line !== exp_line) begin
            n_fail++;
            $display("FAIL timeout_recover: resp_o=%b err_o=%b line_o=%h, want 1 0 %h",
                     t_resp, t_err, t_line, exp_line);
        end
        tick;
    endtask

    task automatic test_reset_mid_burst;
        logic [255:0] exp_line;
        int n_resp;
        n_resp = 0;
        line_i = {pat(6, 3), pat(6, 2), pat(6, 1), pat(6, 0)};
        address_i = 32'h0000_2000;
        write_i = 1'b1;
        tick;
        write_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        n_checks++;
        if (d_wr !== 1'b1 || d_burst !== pat(6, 2)) begin
            n_fail++;
            $display("FAIL reset_mid_pre: write_o=%b burst_o=%h, want 1 %h", d_wr, d_burst, pat(6, 2));
        end
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        n_checks++;
        if (d_wr !== 1'b0 || d_burst !== 64'h0 || w_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drop: write_o=%b burst_o=%h, want 0 0", d_wr, d_burst);
        end
        for (int c = 0; c < 4; c++) begin
            if (d_resp === 1'b1 || t_resp === 1'b1 || w_resp === 1'b1) n_resp++;
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        n_checks++;
        if (n_resp !== 0 || d_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_resp: resp_o pulses=%0d write_o=%b, want 0 0", n_resp, d_wr);
        end
        exp_line = {pat(7, 3), pat(7, 2), pat(7, 1), pat(7, 0)};
        read_i = 1'b1;
        tick;
        read_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            burst_i = pat(7, b);
            burst2_i = pat2(7, b);
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        n_checks++;
        if (d_resp !== 1'b1 || d_err !== 1'b0 || d_line !== exp_line) begin
            n_fail++;
            $display("FAIL reset_mid_recover: resp_o=%b err_o=%b line_o=%h, want 1 0 %h",
                     d_resp, d_err, d_line, exp_line);
        end
        tick;
    endtask

    initial begin
        reset_n   = 1'b0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        resp_i    = 1'b0;
        line_i    = '0;
        line2_i   = '0;
        burst_i   = '0;
        burst2_i  = '0;
        #1;
        test_reset;
        test_read;
        test_write;
        test_read_write_collision;
        test_timeout;
        test_reset_mid_burst;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
